// File: rtl/ovl_fire_collector_pkg.sv
// Shared constants for the checker fire collector: event kinds, FSM encodings
// and the width of one queued event record ({id, kind}).
package ovl_fire_collector_pkg;

  localparam logic KIND_2STATE = 1'b0;
  localparam logic KIND_XCHECK = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // One event record is the checker index plus a single kind bit.
  function automatic int evt_w(input int idw);
    return idw + 1;
  endfunction

endpackage

// File: rtl/ovl_fire_fifo.sv
// Small synchronous FIFO for fire events. Push and pop may happen in the same
// cycle, including when full. The caller never pushes into a full FIFO without
// a pop, and never pops an empty one.
module ovl_fire_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wp, rp;
  logic [AW:0]             cnt;

  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);
  assign dout  = mem[rp];

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ovl_fire_collector.sv
// Single reporting point for all bound OVL checkers. Fire pulses are merged
// into pending vectors, scanned one per cycle (lowest pending 2-state index,
// else lowest pending xcheck index) into an event FIFO, and summarised in
// sticky first-failure / count / overflow status.
// Optional build macro: OVL_FIRE_XZ_EN -- X/Z on either fire input of a
// checker is reported as an xcheck event for that checker.
module ovl_fire_collector
  import ovl_fire_collector_pkg::*;
#(
  parameter  int NUM_CHECKERS = 8,
  parameter  int FIFO_DEPTH   = 4,
  parameter  int CNT_WIDTH    = 16,
  localparam int IDW          = (NUM_CHECKERS > 1) ? $clog2(NUM_CHECKERS) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [NUM_CHECKERS-1:0] fire_2state,
  input  logic [NUM_CHECKERS-1:0] fire_xcheck,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [IDW-1:0]          evt_id,
  output logic                    evt_kind,
  output logic                    first_valid,
  output logic [IDW-1:0]          first_id,
  output logic [CNT_WIDTH-1:0]    first_ts,
  output logic [CNT_WIDTH-1:0]    fail_count,
  output logic                    overflow
);

  localparam int EW  = evt_w(IDW);
  localparam int PCW = $clog2(2*NUM_CHECKERS + 1);

  logic [NUM_CHECKERS-1:0] f2, fx, pend2, pendx, clr2, clrx;
  logic [NUM_CHECKERS-1:0] kept2, keptx, ovf2, ovfx, new2, newx;
  logic [IDW-1:0]          id2, idx, sel_id, fid;
  logic                    has2, hasx, any_n, anyf, sel_kind;
  logic                    push, pop, push_ok, full, empty;
  logic [PCW-1:0]          inc;
  logic [CNT_WIDTH:0]      sum;
  logic [CNT_WIDTH-1:0]    ts;
  logic [EW-1:0]           dout;
  state_t                  state;

  // Qualify fire bits: only a solid 1 counts unless X/Z reporting is built in.
  always_comb begin
    f2 = '0;
    fx = '0;
    for (int i = 0; i < NUM_CHECKERS; i++) begin
`ifdef OVL_FIRE_XZ_EN
      f2[i] = (fire_2state[i] === 1'b1);
      fx[i] = (fire_xcheck[i] === 1'b1) | $isunknown(fire_2state[i])
            | $isunknown(fire_xcheck[i]);
`else
      f2[i] = (fire_2state[i] === 1'b1);
      fx[i] = (fire_xcheck[i] === 1'b1);
`endif
    end
    f2 = f2 & {NUM_CHECKERS{enable}};
    fx = fx & {NUM_CHECKERS{enable}};
  end

  // Priority encoders: lowest pending index per kind, lowest fired index for the first record.
  always_comb begin
    id2 = '0;
    idx = '0;
    fid = '0;
    for (int i = NUM_CHECKERS-1; i >= 0; i--) begin
      if (pend2[i]) id2 = IDW'(i);
      if (pendx[i]) idx = IDW'(i);
    end
    for (int i = NUM_CHECKERS-1; i >= 0; i--) if (fx[i]) fid = IDW'(i);
    for (int i = NUM_CHECKERS-1; i >= 0; i--) if (f2[i]) fid = IDW'(i);
  end

  assign has2     = |pend2;
  assign hasx     = |pendx;
  assign sel_kind = has2 ? KIND_2STATE : KIND_XCHECK;
  assign sel_id   = has2 ? id2 : idx;
  assign pop      = !empty && evt_ready;
  assign push_ok  = !full || pop;
  assign push     = (has2 || hasx) && push_ok;
  assign clr2     = (push && has2)  ? (NUM_CHECKERS'(1) << id2) : '0;
  assign clrx     = (push && !has2) ? (NUM_CHECKERS'(1) << idx) : '0;

  // A fire on a bit the scanner drains this cycle re-arms it as a fresh event.
  assign kept2 = pend2 & ~clr2;
  assign keptx = pendx & ~clrx;
  assign ovf2  = f2 & kept2;
  assign ovfx  = fx & keptx;
  assign new2  = f2 & ~kept2;
  assign newx  = fx & ~keptx;
  assign any_n = |(kept2 | f2) || |(keptx | fx);
  assign anyf  = |f2 || |fx;

  // Count of newly armed bits, then saturating add onto the (possibly cleared) count.
  always_comb begin
    inc = '0;
    for (int i = 0; i < NUM_CHECKERS; i++)
      inc = inc + PCW'(new2[i]) + PCW'(newx[i]);
    sum = {1'b0, (clear ? '0 : fail_count)} + (CNT_WIDTH+1)'(inc);
  end

  // Free-running timestamp.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ts <= '0;
    else          ts <= ts + 1'b1;
  end

  // Pending vectors: merge new fires, drop the bit just pushed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend2 <= '0;
      pendx <= '0;
    end else begin
      pend2 <= kept2 | f2;
      pendx <= keptx | fx;
    end
  end

  // Status: clear drops old values, but a fire in the same cycle is still recorded.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      first_valid <= 1'b0;
      first_id    <= '0;
      first_ts    <= '0;
      fail_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if ((clear || !first_valid) && anyf) begin
        first_valid <= 1'b1;
        first_id    <= fid;
        first_ts    <= ts;
      end else if (clear) begin
        first_valid <= 1'b0;
        first_id    <= '0;
        first_ts    <= '0;
      end
      fail_count <= sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
      overflow   <= (overflow && !clear) || |(ovf2 | ovfx);
    end
  end

  // Scanner state: idle, actively pushing, or blocked on a full FIFO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else begin
      case (state)
        ST_IDLE:  if (any_n) state <= ST_SCAN;
        ST_SCAN:  if (!any_n) state <= ST_IDLE;
                  else if ((has2 || hasx) && !push_ok) state <= ST_STALL;
        ST_STALL: if (pop) state <= any_n ? ST_SCAN : ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  ovl_fire_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     ({sel_id, sel_kind}),
    .dout    (dout),
    .full    (full),
    .empty   (empty)
  );

  assign evt_valid          = !empty;
  assign {evt_id, evt_kind} = dout;

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Bench for ovl_fire_collector: table of single-cycle fire patterns with
// expected event order and status, plus hand sequences for overflow, stall,
// clear, X handling and mid-run reset. Events are checked via a scoreboard.
module tb_ovl_fire_collector;

  localparam int N  = 8;
  localparam int CW = 16;

  logic          clock = 1'b0, reset_n = 1'b0, enable = 1'b0, clear = 1'b0;
  logic          evt_ready = 1'b0;
  logic [N-1:0]  fire_2state = '0, fire_xcheck = '0;
  logic          evt_valid, evt_kind, first_valid, overflow;
  logic [2:0]    evt_id, first_id;
  logic [CW-1:0] first_ts, fail_count, tb_ts, fts;

  ovl_fire_collector #(.NUM_CHECKERS(N), .FIFO_DEPTH(4), .CNT_WIDTH(CW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear       (clear),
    .fire_2state (fire_2state),
    .fire_xcheck (fire_xcheck),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .evt_kind    (evt_kind),
    .first_valid (first_valid),
    .first_id    (first_id),
    .first_ts    (first_ts),
    .fail_count  (fail_count),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  // Reference cycle counter for timestamp expectations.
  always @(posedge clock or negedge reset_n)
    if (!reset_n) tb_ts <= '0;
    else          tb_ts <= tb_ts + 1'b1;

  int         n_chk = 0, n_fail = 0;
  logic [3:0] sb[$];   // expected {id, kind}

  typedef struct {
    logic            clr;
    logic [7:0]      f2, fx;
    int              n;
    logic [7:0][3:0] ev;
    logic [15:0]     cnt;
    logic [2:0]      fid;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !evt_valid) break;
      tick();
    end
    chk("drain_left", sb.size(), 0);
    chk("drain_valid", evt_valid, 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Scoreboard: every accepted handshake is compared with the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got %0h expected none", {evt_id, evt_kind});
      end else chk("event", {evt_id, evt_kind}, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // {id,kind} nibbles, first expected event in the low nibble
    vt[0] = '{clr:1'b0, f2:8'h08, fx:8'h00, n:1, ev:32'h0000_0006, cnt:16'd1, fid:3'd3};
    vt[1] = '{clr:1'b1, f2:8'h05, fx:8'h01, n:3, ev:32'h0000_0140, cnt:16'd3, fid:3'd0};
    vt[2] = '{clr:1'b1, f2:8'h00, fx:8'hc0, n:2, ev:32'h0000_00fd, cnt:16'd2, fid:3'd6};
    vt[3] = '{clr:1'b0, f2:8'h80, fx:8'h80, n:2, ev:32'h0000_00fe, cnt:16'd4, fid:3'd6};
    vt[4] = '{clr:1'b1, f2:8'hff, fx:8'h00, n:8, ev:32'heca8_6420, cnt:16'd8, fid:3'd0};
    fts = '0;

    // reset state
    #2;
    chk("rst_valid", evt_valid, 0);
    chk("rst_count", fail_count, 0);
    chk("rst_first", first_valid, 0);
    chk("rst_ovf", overflow, 0);
    tick(); tick();
    reset_n   = 1'b1;
    enable    = 1'b1;
    evt_ready = 1'b1;
    tick();

    // table: one fire cycle each, then drain in order
    for (int v = 0; v < 5; v++) begin
      if (v == 0 || vt[v].clr) fts = tb_ts;
      clear       = vt[v].clr;
      fire_2state = vt[v].f2;
      fire_xcheck = vt[v].fx;
      for (int j = 0; j < vt[v].n; j++) sb.push_back(vt[v].ev[j]);
      tick();
      clear = 1'b0; fire_2state = '0; fire_xcheck = '0;
      chk("vec_count", fail_count, vt[v].cnt);
      chk("vec_first_valid", first_valid, 1);
      chk("vec_first_id", first_id, vt[v].fid);
      chk("vec_first_ts", first_ts, fts);
      chk("vec_ovf", overflow, 0);
      chk("vec_lat_k", evt_valid, 0);
      tick();
      chk("vec_lat_k1", evt_valid, 1);
      drain();
    end

    // enable low: fires ignored
    enable = 1'b0; fire_2state = 8'hff;
    tick();
    fire_2state = '0; enable = 1'b1;
    tick();
    chk("en_off_count", fail_count, 8);
    chk("en_off_valid", evt_valid, 0);

    // fire on a bit drained in the same cycle re-arms it without overflow
    pulse_clear();
    fire_2state = 8'h40; sb.push_back(4'hc);
    tick();
    sb.push_back(4'hc);
    tick();
    fire_2state = '0;
    chk("rearm_ovf", overflow, 0);
    chk("rearm_count", fail_count, 2);
    drain();

    // fire on a still-pending bit merges and flags overflow
    pulse_clear();
    fire_2state = 8'h30; sb.push_back(4'h8); sb.push_back(4'ha);
    tick();
    fire_2state = 8'h20;
    tick();
    fire_2state = '0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", fail_count, 2);
    drain();

    // stall: six fires into a 4-deep FIFO, clear while stalled, then deliver all
    pulse_clear();
    chk("clr_ovf", overflow, 0);
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fire_2state = 8'(1 << i);
      sb.push_back({3'(i), 1'b0});
      tick();
    end
    fire_2state = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("stall_valid", evt_valid, 1);
    chk("stall_head", {evt_id, evt_kind}, 0);
    chk("stall_count", fail_count, 6);
    pulse_clear();
    chk("stall_clr_count", fail_count, 0);
    chk("stall_clr_first", first_valid, 0);
    chk("stall_clr_ts", first_ts, 0);
    chk("stall_clr_valid", evt_valid, 1);
    evt_ready = 1'b1;
    drain();

    // X on a 2-state fire input
    pulse_clear();
    fire_2state = 8'b0000_00x0;
`ifdef OVL_FIRE_XZ_EN
    sb.push_back(4'h3);
`endif
    tick();
    fire_2state = '0;
`ifdef OVL_FIRE_XZ_EN
    chk("x_count", fail_count, 1);
`else
    chk("x_count", fail_count, 0);
`endif
    drain();

    // reset with events queued discards everything at once
    evt_ready = 1'b0;
    fire_2state = 8'h07;
    tick();
    fire_2state = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_valid", evt_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_count", fail_count, 0);
    chk("mid_rst_first", first_valid, 0);
    sb.delete();
    tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_valid", evt_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
